// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared types and elaboration helpers for the multi-channel timer.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_CH = 16;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

    // The prescaler needs an exact integer divide of at least 2.
    function automatic bit div_ok(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 1'b0;
        end
        return ((clk_hz % tick_hz) == 0) && ((clk_hz / tick_hz) >= 2);
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Purpose  : One down-counting timer channel, one-shot or auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             done,
    output logic             expire,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] rem_q,    rem_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             expire_q, expire_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = 1'b0;

        // Abort beats start, and start beats a same-cycle expiry.
        if (abort) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if (start) begin
            rem_d    = load_val;
            reload_d = load_val;
            mode_d   = periodic;
            if (load_val == '0) begin
                state_d  = ST_DONE;
                expire_d = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if ((state_q == ST_RUN) && tick) begin
            if (rem_q <= C_ONE) begin
                expire_d = 1'b1;
                if (mode_q) begin
                    rem_d = reload_q;
                end else begin
                    rem_d   = '0;
                    state_d = ST_DONE;
                end
            end else begin
                rem_d = rem_q - C_ONE;
            end
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign expire    = expire_q;
    assign remaining = rem_q;

endmodule : timer_channel
`default_nettype wire

// File: rtl/multi_channel_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_timer
// Purpose  : Shared tick prescaler feeding N_CH independent interval timers.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       abort,
    input  logic [N_CH-1:0]       periodic,
    input  logic [N_CH*CNT_W-1:0] load_val,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       done,
    output logic [N_CH-1:0]       expire,
    output logic [N_CH*CNT_W-1:0] remaining,
    output logic                  tick
);

    localparam int DIV  = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int PS_W = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] C_PS_MAX = PS_W'(DIV - 1);

    if (!div_ok(CLK_FREQ_HZ, TICK_HZ)) begin : g_div_check
        $error("multi_channel_timer: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
    end

    if ((N_CH < 1) || (N_CH > MAX_CH)) begin : g_nch_check
        $error("multi_channel_timer: N_CH must be in 1..16");
    end

    logic [PS_W-1:0] ps_q,   ps_d;
    logic            tick_q, tick_d;

    // tick is registered from the next count so it is high exactly while the count sits at DIV-1.
    always_comb begin
        ps_d   = (ps_q == C_PS_MAX) ? '0 : ps_q + PS_W'(1);
        tick_d = (ps_d == C_PS_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick_q),
            .start     (start[i]),
            .abort     (abort[i]),
            .periodic  (periodic[i]),
            .load_val  (load_val[i*CNT_W +: CNT_W]),
            .busy      (busy[i]),
            .done      (done[i]),
            .expire    (expire[i]),
            .remaining (remaining[i*CNT_W +: CNT_W])
        );
    end

endmodule : multi_channel_timer
`default_nettype wire
